// File: rtl/mult32x32_arbiter.sv
// mult32x32_arbiter
// Shares one mult32x32_fast multiplier between NUM_REQ requesters (2..4).
// Requests are granted one at a time in round-robin order. The winner's
// operands are latched onto mul_a/mul_b. The multiplier is then started, and
// the 64-bit product is returned to the requester that issued it.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_a/req_b per-requester request and operands (slice i = requester i)
//   req_ready             one-hot grant pulse
//   rsp_valid             one-hot response pulse, product on rsp_product
//   rsp_product           last product, held until the next response
//   arb_busy              high whenever the FSM is not in IDLE
//   mul_start/mul_a/mul_b multiplier start pulse and operands
//   mul_busy/mul_product  multiplier status and product
//
// Optional feature: define MULT_ARB_ZERO_BYPASS_EN to answer requests that
// have a zero operand directly. These requests produce a product of 0 and
// skip the multiplier.
module mult32x32_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [63:0]           rsp_product,
    output logic                  arb_busy,
    output logic                  mul_start,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic                  mul_busy,
    input  logic [63:0]           mul_product
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   last_grant;
    logic [PW-1:0]   id;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   cand;
    logic            found;
    logic            grant;
    logic            bypass;
    logic [31:0]     win_a;
    logic [31:0]     win_b;

    // Round-robin search upward from last_grant+1, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((32'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign win_a = req_a[32*int'(winner) +: 32];
    assign win_b = req_b[32*int'(winner) +: 32];

    // The reset_n term keeps req_ready low while reset is asserted, so that
    // every output reads 0 during reset even if requests are already pending.
    assign grant = reset_n && (state == IDLE) && found && !mul_busy;

`ifdef MULT_ARB_ZERO_BYPASS_EN
    assign bypass = grant && ((win_a == '0) || (win_b == '0));
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        arb_busy  = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant) begin
                    req_ready = NUM_REQ'(1) << winner;
                    state_nx  = bypass ? DONE : START;
                end
            end
            START: begin
                mul_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (!mul_busy) state_nx = DONE;
            end
            DONE: begin
                rsp_valid = NUM_REQ'(1) << id;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= PW'(NUM_REQ - 1);
            id          <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_product <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                last_grant <= winner;
                id         <= winner;
                mul_a      <= win_a;
                mul_b      <= win_b;
            end
            if (bypass) begin
                rsp_product <= '0;
            end else if (state == WAIT && !mul_busy) begin
                rsp_product <= mul_product;
            end
        end
    end

endmodule

// File: tb/tb_mult32x32_arbiter.sv
module tb_mult32x32_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [63:0] rsp_product;
    logic        arb_busy;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_busy;
    logic [63:0] mul_product;

    int n_cmp = 0;
    int n_err = 0;

    // Multiplier stand-in: 4 busy cycles after start, full unsigned product.
    int          mcnt = 0;
    logic [63:0] mprod = '0;
    logic        force_busy = 1'b0;

    assign mul_busy    = (mcnt != 0) || force_busy;
    assign mul_product = mprod;

    always @(posedge clk) begin
        if (mul_start) begin
            mcnt  <= 4;
            mprod <= {32'b0, mul_a} * {32'b0, mul_b};
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end

    mult32x32_arbiter #(.NUM_REQ(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .arb_busy    (arb_busy),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_busy    (mul_busy),
        .mul_product (mul_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Drives one request and observes it; lat counts cycles from grant (0) to rsp_valid.
    task automatic run_txn(input int r, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] prod, output logic [1:0] rv,
                           output int starts, output bit unstable, output bit rdy_busy);
        int n;
        logic [31:0] sa, sb;
        lat = -1; prod = '0; rv = '0; starts = 0; unstable = 0; rdy_busy = 0;
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        n = 1;
        sa = mul_a; sb = mul_b;
        while (rsp_valid === 2'b00 && n < 30) begin
            if (mul_start === 1'b1) starts++;
            if (mul_a !== sa || mul_b !== sb) unstable = 1;
            if ((|req_ready) && arb_busy) rdy_busy = 1;
            @(posedge clk); #1; n++;
        end
        if (mul_a !== sa || mul_b !== sb) unstable = 1;
        if (rsp_valid !== 2'b00) begin
            lat = n; prod = rsp_product; rv = rsp_valid;
        end
    endtask

    task automatic test_reset();
        req_valid = '0; req_a = '0; req_b = '0;
        do_reset();
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %h exp 0", rsp_valid); end
        n_cmp++; if (rsp_product !== 64'h0) begin n_err++; $display("FAIL reset_rsp_product got %h exp 0", rsp_product); end
        n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL reset_arb_busy got %b exp 0", arb_busy); end
        n_cmp++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL reset_mul_start got %b exp 0", mul_start); end
        n_cmp++; if (mul_a !== 32'h0) begin n_err++; $display("FAIL reset_mul_a got %h exp 0", mul_a); end
        n_cmp++; if (mul_b !== 32'h0) begin n_err++; $display("FAIL reset_mul_b got %h exp 0", mul_b); end
    endtask

    task automatic test_single();
        int lat, starts; logic [63:0] prod; logic [1:0] rv; bit unst, rb;
        run_txn(0, 32'd3, 32'd5, lat, prod, rv, starts, unst, rb);
        n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL single_latency got %0d exp 7", lat); end
        n_cmp++; if (prod !== 64'd15) begin n_err++; $display("FAIL single_product got %h exp 15", prod); end
        n_cmp++; if (rv !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid got %b exp 01", rv); end
        n_cmp++; if (starts !== 1) begin n_err++; $display("FAIL single_mul_start got %0d pulses exp 1", starts); end
        n_cmp++; if (rb !== 1'b0) begin n_err++; $display("FAIL single_ready_while_busy got %b exp 0", rb); end
        @(posedge clk); #1;
        n_cmp++; if (arb_busy !== 1'b0 || rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_back_idle got busy=%b rv=%b exp 0/00", arb_busy, rsp_valid); end
        n_cmp++; if (rsp_product !== 64'd15) begin n_err++; $display("FAIL single_product_held got %h exp 15", rsp_product); end
    endtask

    task automatic test_full_width();
        int lat, starts; logic [63:0] prod; logic [1:0] rv; bit unst, rb;
        run_txn(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, prod, rv, starts, unst, rb);
        n_cmp++; if (prod !== 64'hFFFF_FFFE_0000_0001) begin n_err++; $display("FAIL full_product got %h exp fffffffe00000001", prod); end
        n_cmp++; if (rv !== 2'b10) begin n_err++; $display("FAIL full_rsp_valid got %b exp 10", rv); end
        n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL full_latency got %0d exp 7", lat); end
        n_cmp++; if (unst !== 1'b0) begin n_err++; $display("FAIL full_operand_stable got unstable=%b exp 0", unst); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_operand();
        int lat, starts, exp_lat, exp_starts; logic [63:0] prod; logic [1:0] rv; bit unst, rb;
`ifdef MULT_ARB_ZERO_BYPASS_EN
        exp_lat = 1; exp_starts = 0;
`else
        exp_lat = 7; exp_starts = 1;
`endif
        run_txn(0, 32'd0, 32'd7, lat, prod, rv, starts, unst, rb);
        n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL zero_latency got %0d exp %0d", lat, exp_lat); end
        n_cmp++; if (prod !== 64'd0) begin n_err++; $display("FAIL zero_product got %h exp 0", prod); end
        n_cmp++; if (starts !== exp_starts) begin n_err++; $display("FAIL zero_mul_start got %0d exp %0d", starts, exp_starts); end
        n_cmp++; if (rv !== 2'b01) begin n_err++; $display("FAIL zero_rsp_valid got %b exp 01", rv); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  grants[4];
        logic [1:0]  rsps[4];
        logic [63:0] prods[4];
        logic [1:0]  exp_g[4];
        logic [63:0] exp_p[4];
        int ng, nr, n;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        exp_p[0] = 64'd6; exp_p[1] = 64'd20; exp_p[2] = 64'd6; exp_p[3] = 64'd20;
        for (int i = 0; i < 4; i++) begin grants[i] = '0; rsps[i] = '0; prods[i] = '0; end
        req_a = {32'd4, 32'd2};
        req_b = {32'd5, 32'd3};
        req_valid = 2'b11;
        do_reset();
        #1;
        ng = 0; nr = 0; n = 0;
        while (nr < 4 && n < 120) begin
            if (|req_ready && ng < 4) begin grants[ng] = req_ready; ng++; end
            if (|rsp_valid) begin rsps[nr] = rsp_valid; prods[nr] = rsp_product; nr++; end
            @(posedge clk); #1; n++;
        end
        req_valid = 2'b00;
        n_cmp++; if (nr !== 4) begin n_err++; $display("FAIL b2b_response_count got %0d exp 4", nr); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (grants[i] !== exp_g[i]) begin n_err++; $display("FAIL b2b_grant%0d got %b exp %b", i, grants[i], exp_g[i]); end
            n_cmp++; if (rsps[i] !== exp_g[i]) begin n_err++; $display("FAIL b2b_rsp_id%0d got %b exp %b", i, rsps[i], exp_g[i]); end
            n_cmp++; if (prods[i] !== exp_p[i]) begin n_err++; $display("FAIL b2b_product%0d got %h exp %h", i, prods[i], exp_p[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int lat, starts; logic [63:0] prod; logic [1:0] rv; bit unst, rb, bad;
        req_a[31:0] = 32'd9; req_b[31:0] = 32'd9; req_valid = 2'b01;
        #1;
        @(posedge clk); #1;   // START
        req_valid = 2'b00;
        @(posedge clk); #1;   // WAIT, first busy cycle
        @(posedge clk); #1;   // WAIT
        n_cmp++; if (arb_busy !== 1'b1) begin n_err++; $display("FAIL mid_precond_busy got %b exp 1", arb_busy); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (arb_busy !== 1'b0 || mul_start !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00)
            begin n_err++; $display("FAIL mid_reset_ctrl got busy=%b start=%b rdy=%b rv=%b exp all 0", arb_busy, mul_start, req_ready, rsp_valid); end
        n_cmp++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin n_err++; $display("FAIL mid_reset_operands got %h/%h exp 0/0", mul_a, mul_b); end
        n_cmp++; if (rsp_product !== 64'h0) begin n_err++; $display("FAIL mid_reset_product got %h exp 0", rsp_product); end
        force_busy = 1'b1;
        bad = 0;
        @(posedge clk); #1;
        if (rsp_valid !== 2'b00) bad = 1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        req_a[63:32] = 32'd2; req_b[63:32] = 32'd2; req_valid = 2'b10;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || arb_busy !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL mid_no_grant_while_mul_busy got activity=%b exp 0", bad); end
        force_busy = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL mid_grant_after_busy got %b exp 10", req_ready); end
        run_txn(1, 32'd2, 32'd2, lat, prod, rv, starts, unst, rb);
        n_cmp++; if (prod !== 64'd4 || rv !== 2'b10) begin n_err++; $display("FAIL mid_post_reset_txn got prod=%h rv=%b exp 4/10", prod, rv); end
        n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL mid_post_reset_latency got %0d exp 7", lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        test_reset();
        test_single();
        test_full_width();
        test_zero_operand();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
